// File: rtl/fft_pkg.sv
// Package shared by the FFT input framer and the FFT core.
// Holds the default data width and frame size, the replay FSM state type
// and the bit-reversal helper used to produce DIT input order.
package fft_pkg;

  localparam int FFT_DATA_W    = 24;
  localparam int FFT_LOG2N     = 4;
  localparam int FFT_MAX_LOG2N = 10;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

  // Reverse the low log2n bits of value. The whole word is mirrored first,
  // then shifted down so the reversed field lands in the low bits again.
  // Bits of value at or above log2n must be zero.
  function automatic logic [FFT_MAX_LOG2N-1:0] bitrev(
    input logic [FFT_MAX_LOG2N-1:0] value,
    input int                       log2n
  );
    logic [FFT_MAX_LOG2N-1:0] mirrored;
    for (int i = 0; i < FFT_MAX_LOG2N; i++) begin
      mirrored[i] = value[FFT_MAX_LOG2N-1-i];
    end
    return mirrored >> (FFT_MAX_LOG2N - log2n);
  endfunction

endpackage

// File: rtl/fft_frame_buffer_if.sv
// Stream bundle between a sample source/sink and fft_frame_buffer.
//   in_x/in_nd            : input sample and its new-data strobe
//   out_x/out_idx/out_nd  : replayed sample, its natural index, valid
//   out_ready             : downstream accept
//   out_first/out_last    : frame delimiters, qualified by out_nd
//   overflow              : one-cycle drop pulse
// slave  = the framer's view, master = the environment's view.
interface fft_frame_buffer_if
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int LOG2N  = FFT_LOG2N
);
  logic [DATA_W-1:0] in_x;
  logic              in_nd;
  logic [DATA_W-1:0] out_x;
  logic [LOG2N-1:0]  out_idx;
  logic              out_nd;
  logic              out_ready;
  logic              out_first;
  logic              out_last;
  logic              overflow;

  modport slave (
    input  in_x, in_nd, out_ready,
    output out_x, out_idx, out_nd, out_first, out_last, overflow
  );

  modport master (
    output in_x, in_nd, out_ready,
    input  out_x, out_idx, out_nd, out_first, out_last, overflow
  );
endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame store: 2*N words of DATA_W bits. The address MSB selects
// the bank. One synchronous write port, one asynchronous read port so the
// framer can load its output register in the same cycle it picks an address.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : {bank, index} write address
//   wdata_i : write data
//   raddr_i : {bank, index} read address
//   rdata_o : read data (combinational)
module fft_pingpong_ram
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int LOG2N  = FFT_LOG2N
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [LOG2N:0]    waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [LOG2N:0]    raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int DEPTH = 2 << LOG2N;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong input framer for the streaming DIT FFT.
// Collects N = 2**LOG2N samples into one bank while the other bank is replayed
// (bit-reversed when BITREV=1, natural order otherwise) under ready/valid.
//   clk     : clock, all state on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : fft_frame_buffer_if.slave (input stream, output stream, overflow)
module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int LOG2N  = FFT_LOG2N,
  parameter bit BITREV = 1'b1
) (
  input logic               clk,
  input logic               reset_n,
  fft_frame_buffer_if.slave bus
);
  localparam int               N        = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_CNT = LOG2N'(N - 1);

  rd_state_e         state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic [LOG2N-1:0]  wr_cnt_q, wr_cnt_d;
  logic              rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0]  rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] out_x_q, out_x_d;
  logic [LOG2N-1:0]  out_idx_q, out_idx_d;
  logic              out_nd_q, out_nd_d;
  logic              out_first_q, out_first_d;
  logic              out_last_q, out_last_d;
  logic              overflow_q, overflow_d;

  logic              xfer, last_xfer, load, wr_en;
  logic              ld_bank;
  logic [LOG2N-1:0]  ld_cnt, rd_addr;
  logic [DATA_W-1:0] ram_rdata;

  // Select what the output register loads this cycle. Kept separate from
  // the next-state logic because the RAM read data depends on it.
  always_comb begin
    xfer      = out_nd_q & bus.out_ready;
    last_xfer = xfer & out_last_q;
    load      = 1'b0;
    ld_bank   = rd_bank_q;
    ld_cnt    = '0;
    if (state_q == RD_IDLE) begin
      load = full_q[rd_bank_q];
    end else if (xfer) begin
      if (out_last_q) begin
        // Chain straight into the other bank when it is already waiting.
        ld_bank = ~rd_bank_q;
        load    = full_q[~rd_bank_q];
      end else begin
        load   = 1'b1;
        ld_cnt = rd_cnt_q + 1'b1;
      end
    end
  end

  assign rd_addr = BITREV ? LOG2N'(bitrev(FFT_MAX_LOG2N'(ld_cnt), LOG2N)) : ld_cnt;

  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    out_x_d     = out_x_q;
    out_idx_d   = out_idx_q;
    out_nd_d    = out_nd_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;

    // A full bank still accepts a write in the cycle its last sample leaves.
    wr_en      = bus.in_nd &
                 (~full_q[wr_bank_q] | (last_xfer & (rd_bank_q == wr_bank_q)));
    overflow_d = bus.in_nd & ~wr_en;

    if (last_xfer) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    if (wr_en) begin
      if (wr_cnt_q == LAST_CNT) begin
        wr_cnt_d          = '0;
        wr_bank_d         = ~wr_bank_q;
        full_d[wr_bank_q] = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    if (load) begin
      state_d     = RD_STREAM;
      rd_cnt_d    = ld_cnt;
      out_x_d     = ram_rdata;
      out_idx_d   = rd_addr;
      out_nd_d    = 1'b1;
      out_first_d = (ld_cnt == '0);
      out_last_d  = (ld_cnt == LAST_CNT);
    end else if (last_xfer) begin
      state_d     = RD_IDLE;
      out_nd_d    = 1'b0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RD_IDLE;
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      out_x_q     <= '0;
      out_idx_q   <= '0;
      out_nd_q    <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      out_x_q     <= out_x_d;
      out_idx_q   <= out_idx_d;
      out_nd_q    <= out_nd_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
    end
  end

  fft_pingpong_ram #(
    .DATA_W (DATA_W),
    .LOG2N  (LOG2N)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i ({wr_bank_q, wr_cnt_q}),
    .wdata_i (bus.in_x),
    .raddr_i ({ld_bank, rd_addr}),
    .rdata_o (ram_rdata)
  );

  assign bus.out_x     = out_x_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_nd    = out_nd_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_fft_frame_buffer.sv
// Bench for fft_frame_buffer. Two instances (bit-reversed and natural order)
// share one stimulus. A frame-level model predicts every output sample and
// every overflow pulse; directed literal tables pin the model.
module tb_fft_frame_buffer;
  localparam int DW = 24;
  localparam int L2 = 4;
  localparam int N  = 16;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic [DW-1:0] in_x      = '0;
  logic          in_nd     = 1'b0;
  logic          out_ready = 1'b0;

  always #5 clk = ~clk;

  fft_frame_buffer_if #(.DATA_W(DW), .LOG2N(L2)) if_rev ();
  fft_frame_buffer_if #(.DATA_W(DW), .LOG2N(L2)) if_nat ();

  assign if_rev.in_x      = in_x;
  assign if_rev.in_nd     = in_nd;
  assign if_rev.out_ready = out_ready;
  assign if_nat.in_x      = in_x;
  assign if_nat.in_nd     = in_nd;
  assign if_nat.out_ready = out_ready;

  fft_frame_buffer #(.DATA_W(DW), .LOG2N(L2), .BITREV(1'b1)) u_rev (
    .clk(clk), .reset_n(reset_n), .bus(if_rev));
  fft_frame_buffer #(.DATA_W(DW), .LOG2N(L2), .BITREV(1'b0)) u_nat (
    .clk(clk), .reset_n(reset_n), .bus(if_nat));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: per instance, up to 4 stored complete frames and one partial frame.
  logic [DW-1:0] mf   [2][4][N];
  logic [DW-1:0] wbuf [2][N];
  int            hd [2], cnt [2], pos [2], wn [2];
  logic          exp_ovf [2];

  // Observations and bookkeeping.
  logic [DW-1:0] o_x [2];
  logic [L2-1:0] o_idx [2];
  logic          o_nd [2], o_first [2], o_last [2], o_ovf [2];
  logic [DW-1:0] p_x [2];
  logic [L2-1:0] p_idx [2];
  logic          p_nd [2], p_first [2], p_last [2];
  logic          p_ready = 1'b0;
  logic [DW-1:0] cap_x  [2][128];
  int            cap_idx[2][128];
  int            cap_fl [2][128];
  int            cap_n [2], ovf_n [2], bubbles [2], rise_cyc [2];
  int            bub_limit   = 0;
  int            last_in_cyc = 0;
  int            k, ei;
  logic [DW-1:0] ex;

  int t1_in  [16] = '{0, 38, 70, 92, 100, 92, 70, 38, 0, -38, -70, -92, -100, -92, -70, -38};
  int t1_x   [16] = '{0, 0, 100, -100, 70, -70, 70, -70, 38, -38, 92, -92, 92, -92, 38, -38};
  int t1_idx [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  function automatic int rev_idx(input int kk);
    int r = 0;
    int v = kk;
    for (int b = 0; b < L2; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      hd[d] = 0; cnt[d] = 0; pos[d] = 0; wn[d] = 0; exp_ovf[d] = 1'b0;
      p_nd[d] = 1'b0; p_first[d] = 1'b0; p_last[d] = 1'b0;
      p_x[d] = '0; p_idx[d] = '0;
    end
  endtask

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      cap_n[d] = 0; ovf_n[d] = 0; bubbles[d] = 0; rise_cyc[d] = -1;
    end
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  initial begin
    model_clear();
    clear_stats();
    forever begin
      @(negedge clk);
      o_x[0] = if_rev.out_x;     o_x[1] = if_nat.out_x;
      o_idx[0] = if_rev.out_idx; o_idx[1] = if_nat.out_idx;
      o_nd[0] = if_rev.out_nd;   o_nd[1] = if_nat.out_nd;
      o_first[0] = if_rev.out_first; o_first[1] = if_nat.out_first;
      o_last[0] = if_rev.out_last;   o_last[1] = if_nat.out_last;
      o_ovf[0] = if_rev.overflow;    o_ovf[1] = if_nat.overflow;
      if (!reset_n) begin
        for (int d = 0; d < 2; d++) begin
          tests++;
          if (o_nd[d] || o_first[d] || o_last[d] || o_ovf[d] || o_x[d] != '0 || o_idx[d] != '0) begin
            fails++;
            $display("FAIL reset_state dut%0d: nd=%0b first=%0b last=%0b ovf=%0b x=%0h idx=%0d, required all 0",
                     d, o_nd[d], o_first[d], o_last[d], o_ovf[d], o_x[d], o_idx[d]);
          end
        end
        model_clear();
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (p_nd[d] && !p_ready) begin
            tests++;
            if (!o_nd[d] || o_x[d] != p_x[d] || o_idx[d] != p_idx[d] ||
                o_first[d] != p_first[d] || o_last[d] != p_last[d]) begin
              fails++;
              $display("FAIL stall_hold dut%0d: nd=%0b x=%0h idx=%0d, required nd=1 x=%0h idx=%0d",
                       d, o_nd[d], o_x[d], o_idx[d], p_x[d], p_idx[d]);
            end
          end
          if (o_nd[d] && !p_nd[d] && rise_cyc[d] < 0) rise_cyc[d] = cyc;
          if (!o_nd[d] && cap_n[d] > 0 && cap_n[d] < bub_limit) bubbles[d]++;
          if (o_nd[d]) begin
            tests++;
            if (cnt[d] == 0) begin
              fails++;
              $display("FAIL out_nd_spurious dut%0d: out_nd=1, required 0", d);
            end else begin
              k  = pos[d];
              ei = (d == 0) ? rev_idx(k) : k;
              ex = mf[d][hd[d]][ei];
              if (o_x[d] != ex || int'(o_idx[d]) != ei ||
                  o_first[d] != (k == 0) || o_last[d] != (k == N - 1)) begin
                fails++;
                $display("FAIL sample dut%0d k=%0d: x=%0d idx=%0d first=%0b last=%0b, required x=%0d idx=%0d first=%0b last=%0b",
                         d, k, $signed(o_x[d]), o_idx[d], o_first[d], o_last[d],
                         $signed(ex), ei, (k == 0), (k == N - 1));
              end
            end
            if (out_ready) begin
              if (cap_n[d] < 128) begin
                cap_x[d][cap_n[d]]   = o_x[d];
                cap_idx[d][cap_n[d]] = int'(o_idx[d]);
                cap_fl[d][cap_n[d]]  = {30'd0, o_first[d], o_last[d]};
              end
              cap_n[d]++;
              if (cnt[d] > 0) begin
                pos[d]++;
                if (pos[d] == N) begin
                  pos[d] = 0;
                  hd[d]  = (hd[d] + 1) % 4;
                  cnt[d]--;
                  $display("[TB] dut%0d frame out, cycle %0d, %0d samples so far", d, cyc, cap_n[d]);
                end
              end
            end
          end
          tests++;
          if (o_ovf[d] != exp_ovf[d]) begin
            fails++;
            $display("FAIL overflow dut%0d: got %0b, required %0b", d, o_ovf[d], exp_ovf[d]);
          end
          if (o_ovf[d]) ovf_n[d]++;
          exp_ovf[d] = 1'b0;
          if (in_nd) begin
            if (cnt[d] == 2) begin
              exp_ovf[d] = 1'b1;
            end else begin
              wbuf[d][wn[d]] = in_x;
              wn[d]++;
              if (wn[d] == N) begin
                for (int j = 0; j < N; j++) mf[d][(hd[d] + cnt[d]) % 4][j] = wbuf[d][j];
                cnt[d]++;
                wn[d] = 0;
              end
            end
          end
          p_nd[d] = o_nd[d]; p_x[d] = o_x[d]; p_idx[d] = o_idx[d];
          p_first[d] = o_first[d]; p_last[d] = o_last[d];
        end
        if (in_nd) last_in_cyc = cyc;
      end
      p_ready = out_ready;
    end
  end

  task automatic cyc_in(input logic nd, input int x);
    @(posedge clk);
    #1;
    in_nd = nd;
    in_x  = DW'(x);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((cnt[0] != 0 || cnt[1] != 0) && n < budget) begin
      cyc_in(1'b0, 0);
      n++;
    end
    chk(name, longint'(cnt[0] + cnt[1]), 0);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_nd"},    longint'({if_rev.out_nd, if_nat.out_nd}), 0);
    chk({name, "_fl"},    longint'({if_rev.out_first, if_rev.out_last, if_nat.out_first, if_nat.out_last}), 0);
    chk({name, "_ovf"},   longint'({if_rev.overflow, if_nat.overflow}), 0);
    chk({name, "_x_rev"}, longint'(if_rev.out_x), 0);
    chk({name, "_x_nat"}, longint'(if_nat.out_x), 0);
    chk({name, "_idx"},   longint'({if_rev.out_idx, if_nat.out_idx}), 0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    in_nd   = 1'b0;
    #1;
    check_zero("rst_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_zero("reset");

    // Test 1 and 2: one frame, both orders.
    $display("[TB] test 1/2: single frame, bit-reversed and natural");
    out_ready = 1'b1;
    clear_stats();
    for (int i = 0; i < 16; i++) cyc_in(1'b1, t1_in[i]);
    cyc_in(1'b0, 0);
    wait_drain("t1_drain", 60);
    chk("t1_latency_rev", longint'(rise_cyc[0] - last_in_cyc), 2);
    chk("t1_latency_nat", longint'(rise_cyc[1] - last_in_cyc), 2);
    chk("t1_count_rev", cap_n[0], 16);
    chk("t1_count_nat", cap_n[1], 16);
    for (int i = 0; i < 16; i++) begin
      chk("t1_x_rev",   longint'($signed(cap_x[0][i])), t1_x[i]);
      chk("t1_idx_rev", cap_idx[0][i], t1_idx[i]);
      chk("t1_fl_rev",  cap_fl[0][i], (i == 0) ? 2 : ((i == 15) ? 1 : 0));
      chk("t2_x_nat",   longint'($signed(cap_x[1][i])), t1_in[i]);
      chk("t2_idx_nat", cap_idx[1][i], i);
    end

    // Test 3: blocked output, 40 inputs.
    $display("[TB] test 3: output blocked, 40 inputs");
    out_ready = 1'b0;
    clear_stats();
    for (int i = 0; i < 40; i++) cyc_in(1'b1, 1000 + i);
    cyc_in(1'b0, 0);
    cyc_in(1'b0, 0);
    chk("t3_ovf_rev", ovf_n[0], 8);
    chk("t3_ovf_nat", ovf_n[1], 8);
    chk("t3_blocked", cap_n[0] + cap_n[1], 0);
    out_ready = 1'b1;
    wait_drain("t3_drain", 100);
    chk("t3_count_rev", cap_n[0], 32);
    chk("t3_count_nat", cap_n[1], 32);
    for (int i = 0; i < 32; i += 5) chk("t3_x_nat", longint'(cap_x[1][i]), 1000 + i);
    chk("t3_x_rev_1", longint'(cap_x[0][1]), 1008);
    chk("t3_x_rev_17", longint'(cap_x[0][17]), 1024);

    // Test 4: continuous stream, five frames.
    $display("[TB] test 4: continuous five frames");
    clear_stats();
    bub_limit = 80;
    for (int i = 0; i < 80; i++) cyc_in(1'b1, i * 7 - 200);
    cyc_in(1'b0, 0);
    wait_drain("t4_drain", 60);
    bub_limit = 0;
    chk("t4_bubbles_rev", bubbles[0], 0);
    chk("t4_bubbles_nat", bubbles[1], 0);
    chk("t4_ovf", ovf_n[0] + ovf_n[1], 0);
    chk("t4_count_rev", cap_n[0], 80);
    chk("t4_x_nat_last", longint'($signed(cap_x[1][79])), 79 * 7 - 200);

    // Test 5: write into the bank whose last sample leaves in the same cycle.
    $display("[TB] test 5: simultaneous free and write");
    out_ready = 1'b0;
    clear_stats();
    for (int i = 0; i < 32; i++) cyc_in(1'b1, 5000 + i);
    repeat (3) cyc_in(1'b0, 0);
    cyc_in(1'b0, 0);
    out_ready = 1'b1;
    repeat (14) cyc_in(1'b0, 0);
    for (int i = 0; i < 16; i++) cyc_in(1'b1, 6000 + i);
    cyc_in(1'b0, 0);
    wait_drain("t5_drain", 80);
    chk("t5_ovf", ovf_n[0] + ovf_n[1], 0);
    chk("t5_count_rev", cap_n[0], 48);
    chk("t5_count_nat", cap_n[1], 48);
    for (int i = 0; i < 16; i += 3) chk("t5_x_nat", longint'(cap_x[1][32 + i]), 6000 + i);
    chk("t5_x_rev_33", longint'(cap_x[0][33]), 6008);

    // Test 6a: reset with a partial frame.
    $display("[TB] test 6a: reset mid-frame");
    for (int i = 0; i < 7; i++) cyc_in(1'b1, 9000 + i);
    @(posedge clk);
    #1;
    pulse_reset();
    clear_stats();
    for (int i = 0; i < 16; i++) cyc_in(1'b1, 3000 + i);
    cyc_in(1'b0, 0);
    wait_drain("t6a_drain", 60);
    chk("t6a_count", cap_n[1], 16);
    chk("t6a_x_first", longint'(cap_x[1][0]), 3000);
    chk("t6a_x_rev_1", longint'(cap_x[0][1]), 3008);

    // Test 6b: reset in the middle of a replay.
    $display("[TB] test 6b: reset mid-replay");
    for (int i = 0; i < 16; i++) cyc_in(1'b1, 4000 + i);
    repeat (6) cyc_in(1'b0, 0);
    chk("t6b_streaming", longint'(if_nat.out_nd), 1);
    @(posedge clk);
    #1;
    pulse_reset();
    clear_stats();
    for (int i = 0; i < 16; i++) cyc_in(1'b1, 2000 - i);
    cyc_in(1'b0, 0);
    wait_drain("t6b_drain", 60);
    chk("t6b_count_rev", cap_n[0], 16);
    chk("t6b_count_nat", cap_n[1], 16);
    chk("t6b_x_nat_0", longint'(cap_x[1][0]), 2000);
    chk("t6b_x_nat_15", longint'(cap_x[1][15]), 1985);
    chk("t6b_x_rev_2", longint'(cap_x[0][2]), 1996);

    repeat (2) cyc_in(1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
